// File: rtl/run_log_pkg.sv
// rtl/run_log_pkg.sv - shared constants, tracker states and kind decode for the run event logger
package run_log_pkg;

    localparam logic       RUN_KIND_ZERO      = 1'b0;
    localparam logic       RUN_KIND_ONE       = 1'b1;
    localparam logic [3:0] DET_STATE_ZERO_RUN = 4'd4;
    localparam logic [3:0] DET_STATE_ONE_RUN  = 4'd8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } trk_state_t;

    // Any detector state other than the one-run state is treated as a zero-run.
    function automatic logic kind_of(input logic [3:0] st);
        case (st)
            DET_STATE_ZERO_RUN: return RUN_KIND_ZERO;
            DET_STATE_ONE_RUN:  return RUN_KIND_ONE;
            default:            return RUN_KIND_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/run_fifo.sv
// rtl/run_fifo.sv - run record FIFO with extra-bit pointers; caller only pushes when there is room
module run_fifo
    import run_log_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap is implicit in the AW+1 bit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are only observed through rdata when non-empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/run_event_logger.sv
// rtl/run_event_logger.sv - measures detector runs and queues {kind,len} records; optional RUN_LOG_OVF_CNT_EN adds ovf_cnt
module run_event_logger
    import run_log_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_in,
    input  logic [3:0]       det_state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             ev_kind,
    output logic [LEN_W-1:0] ev_len,
    output logic [CNT_W-1:0] ev_count,
    output logic             busy
`ifdef RUN_LOG_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);

    trk_state_t       state, state_next;
    logic [LEN_W-1:0] len, len_next;
    logic             kind, kind_next;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             empty;
    logic             accept;
    logic [LEN_W:0]   head;

    // Tracker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
            kind  <= RUN_KIND_ZERO;
        end else begin
            state <= state_next;
            len   <= len_next;
            kind  <= kind_next;
        end
    end

    // Run tracking: a kind change while det_in stays high closes one run and opens the next on the same edge.
    always_comb begin
        state_next = state;
        len_next   = len;
        kind_next  = kind;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (det_in) begin
                    state_next = ACTIVE;
                    len_next   = LEN_W'(1);
                    kind_next  = kind_of(det_state);
                end
            end
            ACTIVE: begin
                if (!det_in) begin
                    push_req   = 1'b1;
                    state_next = IDLE;
                    len_next   = '0;
                end else if (kind_of(det_state) != kind) begin
                    push_req   = 1'b1;
                    len_next   = LEN_W'(1);
                    kind_next  = kind_of(det_state);
                end else if (len != '1) begin
                    len_next   = len + LEN_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop    = ev_valid && ev_ready;
    assign accept = push_req && (!full || pop);

    run_fifo #(
        .W     (LEN_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata ({kind, len}),
        .full  (full),
        .empty (empty),
        .rdata (head)
    );

    assign ev_valid         = !empty;
    assign {ev_kind, ev_len} = head;
    assign busy             = (state == ACTIVE);

    // Completed-run counter, counts dropped records too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ev_count <= '0;
        else if (push_req && ev_count != '1)
            ev_count <= ev_count + CNT_W'(1);
    end

`ifdef RUN_LOG_OVF_CNT_EN
    // Dropped-record counter, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_cnt <= '0;
        else if (push_req && !accept && ovf_cnt != 8'hff)
            ovf_cnt <= ovf_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_run_event_logger.sv
// tb/tb_run_event_logger.sv - directed self-checking bench for run_event_logger
module tb_run_event_logger;

    logic        clk = 1'b0;
    logic        reset;
    logic        det_in;
    logic [3:0]  det_state;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_kind;
    logic [7:0]  ev_len;
    logic [15:0] ev_count;
    logic        busy;
`ifdef RUN_LOG_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    run_event_logger #(.LEN_W(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .det_in    (det_in),
        .det_state (det_state),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_kind   (ev_kind),
        .ev_len    (ev_len),
        .ev_count  (ev_count),
        .busy      (busy)
`ifdef RUN_LOG_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic kind, input logic [7:0] len);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_kind"}, 32'(ev_kind), 32'(kind));
        check({tag, "_len"}, 32'(ev_len), 32'(len));
    endtask

    task automatic do_run(input logic [3:0] st, input int n);
        det_state = st;
        det_in    = 1'b1;
        repeat (n) step();
        det_in = 1'b0;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        det_in    = 1'b0;
        det_state = 4'd0;
        ev_ready  = 1'b0;
        repeat (2) step();
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_kind", 32'(ev_kind), 32'd0);
        check("rst_len", 32'(ev_len), 32'd0);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef RUN_LOG_OVF_CNT_EN
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
`endif
        reset = 1'b0;
        step();

        // zero-run of length 3
        det_state = 4'd4;
        det_in    = 1'b1;
        step();
        check("t1_busy", 32'(busy), 32'd1);
        step();
        step();
        det_in = 1'b0;
        check("t1_novalid_yet", 32'(ev_valid), 32'd0);
        step();
        check_head("t1", 1'b0, 8'd3);
        check("t1_count", 32'(ev_count), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        ev_ready = 1'b1;
        step();
        check("t1_popped", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // one-run of 300 cycles saturates length
        do_run(4'd8, 300);
        check_head("t2", 1'b1, 8'd255);
        check("t2_count", 32'(ev_count), 32'd2);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        check("t2_popped", 32'(ev_valid), 32'd0);

        // kind change mid-run: {0,2} then {1,3}
        det_state = 4'd4;
        det_in    = 1'b1;
        step();
        step();
        det_state = 4'd8;
        repeat (3) step();
        det_in = 1'b0;
        step();
        check_head("t5a", 1'b0, 8'd2);
        check("t5_count", 32'(ev_count), 32'd4);
        ev_ready = 1'b1;
        step();
        check_head("t5b", 1'b1, 8'd3);
        step();
        check("t5_empty", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // five runs with no reader: fifth dropped; state 9 counts as zero-run
        do_run(4'd8, 2);
        do_run(4'd4, 2);
        do_run(4'd8, 2);
        do_run(4'd4, 2);
        check("t3_count4", 32'(ev_count), 32'd8);
        do_run(4'd9, 2);
        check("t3_count5", 32'(ev_count), 32'd9);
`ifdef RUN_LOG_OVF_CNT_EN
        check("t3_ovf", 32'(ovf_cnt), 32'd1);
`endif
        check_head("t3a", 1'b1, 8'd2);
        ev_ready = 1'b1;
        step();
        check_head("t3b", 1'b0, 8'd2);
        step();
        check_head("t3c", 1'b1, 8'd2);
        step();
        check_head("t3d", 1'b0, 8'd2);
        step();
        check("t3_empty", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // full FIFO, run ends on the same edge as a pop: accepted
        do_run(4'd4, 1);
        do_run(4'd4, 2);
        do_run(4'd4, 3);
        do_run(4'd4, 4);
        check_head("t4_full", 1'b0, 8'd1);
        det_state = 4'd8;
        det_in    = 1'b1;
        step();
        det_in   = 1'b0;
        ev_ready = 1'b1;
        step();
        check("t4_count", 32'(ev_count), 32'd14);
`ifdef RUN_LOG_OVF_CNT_EN
        check("t4_ovf", 32'(ovf_cnt), 32'd1);
`endif
        check_head("t4a", 1'b0, 8'd2);
        step();
        check_head("t4b", 1'b0, 8'd3);
        step();
        check_head("t4c", 1'b0, 8'd4);
        step();
        check_head("t4d", 1'b1, 8'd1);
        step();
        check("t4_empty", 32'(ev_valid), 32'd0);
        ev_ready = 1'b0;

        // reset mid-run with two records queued
        do_run(4'd8, 2);
        do_run(4'd4, 2);
        det_in = 1'b1;
        step();
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_valid_pre", 32'(ev_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_valid", 32'(ev_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_count", 32'(ev_count), 32'd0);
        det_in = 1'b0;
        step();
        reset = 1'b0;
        repeat (3) step();
        check("t6_valid_post", 32'(ev_valid), 32'd0);
        check("t6_count_post", 32'(ev_count), 32'd0);
        check("t6_busy_post", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/run_event_logger.md
# run_event_logger

Downstream consumer of the run detector: samples its 1-bit detect output and 4-bit state every cycle, measures each detection run (consecutive cycles with detect high), and classifies it as a zero-run (detector state 4) or one-run (detector state 8). Each completed run is queued as a {kind, length} record in a small FIFO that a reader drains with a valid/ready handshake. A saturating total-run counter is also maintained.

## Interface
Parameters:
- LEN_W, 8, run-length field width; length saturates at 2^LEN_W-1
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of total-run counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is asynchronous and active-high
- det_in  in  1  detector output (1 = run in progress)
- det_state  in  4  detector state register value
- ev_valid  out  1  FIFO non-empty; head record presented
- ev_ready  in  1  reader accepts head when ev_valid & ev_ready at edge
- ev_kind  out  1  head record kind: 0 = zero-run, 1 = one-run
- ev_len  out  LEN_W  head record length in cycles
- ev_count  out  CNT_W  completed runs pushed or dropped, saturating
- busy  out  1  a run is currently being measured
- ovf_cnt  out  8  records dropped on full FIFO (only with RUN_LOG_OVF_CNT_EN)

## Operation
- Run tracker, 2 states: IDLE, ACTIVE.
  - IDLE, det_in=1: go ACTIVE, len←1, kind←(det_state==8).
  - ACTIVE, det_in=1, kind unchanged: len←len+1, saturating at all-ones.
  - ACTIVE, det_in=1, det_state kind differs from captured kind: push {kind,len}, restart with len←1 and new kind (same edge).
  - ACTIVE, det_in=0: push {kind,len}, go IDLE.
  - det_state neither 4 nor 8 while det_in=1: kind taken as zero-run.
- Push: if FIFO full and no pop this edge, record is dropped; ev_count still increments.
- Pop: ev_valid & ev_ready at edge removes head.
- Simultaneous push and pop: both take effect; on full FIFO the push is accepted (pop frees the slot).
- Simultaneous push and pop on empty FIFO: pop is impossible (ev_valid=0); push proceeds.
- ev_count increments by 1 per completed run, saturating at 2^CNT_W-1.
- busy = (state==ACTIVE).
- ev_kind/ev_len are don't-care while ev_valid=0; drive 0.

## Timing
- Reset (async assert, release synchronous to clk): state IDLE, len 0, FIFO empty, ev_valid 0, ev_kind 0, ev_len 0, ev_count 0, busy 0, ovf_cnt 0.
- Reset asserted mid-run: in-flight run discarded, no record, FIFO contents lost.
- Length = number of rising edges at which det_in sampled 1 within the run.
- Latency: det_in sampled 0 at edge N ends the run; record written at edge N; ev_valid=1 during cycle N+1 (if FIFO was empty).
- Record popped at edge M; next record visible after edge M (no bubble).
- FIFO pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
- No combinational path from det_in/det_state to any output; ev_valid/ev_kind/ev_len depend only on registers.

## Configuration
- RUN_LOG_OVF_CNT_EN defined: ovf_cnt port present; increments once per dropped record, saturates at 255, reset to 0.
- Not defined: ovf_cnt port absent; drops are silent (ev_count still counts them).

## Structure
- Package run_log_pkg: RUN_KIND_ZERO=0, RUN_KIND_ONE=1, DET_STATE_ZERO_RUN=4, DET_STATE_ONE_RUN=8, tracker state encodings IDLE=0/ACTIVE=1.
- One sub-module: run_fifo (parameterised width LEN_W+1, DEPTH; push/pop/full/empty, head output).
- Tracker, counters and top-level glue in run_event_logger.

## Test plan
- det_state=4, det_in high 3 cycles then low, ev_ready=1 -> one record kind 0, len 3; ev_valid one cycle after det_in low; ev_count=1.
- det_state=8, det_in high 300 cycles, LEN_W=8 -> record kind 1, len 255 (saturated).
- 5 runs of len 2, ev_ready=0, DEPTH=4 -> 4 records held, 5th dropped; ev_count=5; ovf_cnt=1 with macro.
- FIFO full, run ends on same edge as pop -> record accepted, FIFO stays full, no drop.
- det_in held 1, det_state 4 for 2 cycles then 8 for 3 cycles, then 0 -> records {0,2} then {1,3}.
- reset asserted mid-run with 2 records queued -> ev_valid=0, busy=0, ev_count=0 immediately; no record after release.
